// File: rtl/pong_score_keeper.sv
// pong_score_keeper: Pong score keeper. Counts one point per ball exit
// (top row -> player B, bottom row -> player A). It runs a serve handshake with
// the ball-motion logic and latches game-over and the winner when a player
// reaches WIN_SCORE.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   playing             game enable; 0 clears the game back to IDLE
//   ball_valid, ball_y  frame strobe and ball row
//   serve_ack           ball-motion logic has re-served the ball
//   score_a, score_b    player scores
//   point_a, point_b    1-cycle pulse per point scored
//   serve_req           re-serve request, held until serve_ack
//   game_over, winner   game finished; winner 0 = A, 1 = B
module pong_score_keeper #(
   parameter int unsigned COORD_W    = 3,
   parameter int unsigned TOP_ROW    = 0,
   parameter int unsigned BOTTOM_ROW = 7,
   parameter int unsigned SCORE_W    = 4,
   parameter int unsigned WIN_SCORE  = 9
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               playing,
   input  logic               ball_valid,
   input  logic [COORD_W-1:0] ball_y,
   input  logic               serve_ack,
   output logic [SCORE_W-1:0] score_a,
   output logic [SCORE_W-1:0] score_b,
   output logic               point_a,
   output logic               point_b,
   output logic               serve_req,
   output logic               game_over,
   output logic               winner
);

   localparam logic [COORD_W-1:0] TOP_Y   = COORD_W'(TOP_ROW);
   localparam logic [COORD_W-1:0] BOT_Y   = COORD_W'(BOTTOM_ROW);
   localparam logic [SCORE_W-1:0] WIN_VAL = SCORE_W'(WIN_SCORE);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PLAY  = 2'd1,
      SERVE = 2'd2,
      OVER  = 2'd3
   } state_e;

   state_e               state_q, state_d;
   logic [SCORE_W-1:0]   score_a_q, score_a_d;
   logic [SCORE_W-1:0]   score_b_q, score_b_d;
   logic                 point_a_q, point_a_d;
   logic                 point_b_q, point_b_d;
   logic                 serve_req_q, serve_req_d;
   logic                 game_over_q, game_over_d;
   logic                 winner_q, winner_d;

   logic                 hit_a, hit_b;
   logic [SCORE_W-1:0]   inc_a, inc_b;

   // Score events; the two rows differ so at most one can fire per cycle.
   assign hit_a = ball_valid && (ball_y == BOT_Y);
   assign hit_b = ball_valid && (ball_y == TOP_Y);
   assign inc_a = score_a_q + SCORE_W'(1);
   assign inc_b = score_b_q + SCORE_W'(1);

   // Next-state and registered-output logic.
   always_comb begin
      state_d     = state_q;
      score_a_d   = score_a_q;
      score_b_d   = score_b_q;
      point_a_d   = 1'b0;
      point_b_d   = 1'b0;
      serve_req_d = serve_req_q;
      game_over_d = game_over_q;
      winner_d    = winner_q;

      if (!playing) begin
         state_d     = IDLE;
         score_a_d   = '0;
         score_b_d   = '0;
         serve_req_d = 1'b0;
         game_over_d = 1'b0;
         winner_d    = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               score_a_d = '0;
               score_b_d = '0;
               state_d   = PLAY;
            end
            PLAY: begin
               if (hit_a) begin
                  score_a_d = inc_a;
                  point_a_d = 1'b1;
                  if (inc_a == WIN_VAL) begin
                     state_d     = OVER;
                     game_over_d = 1'b1;
                     winner_d    = 1'b0;
                  end else begin
                     state_d     = SERVE;
                     serve_req_d = 1'b1;
                  end
               end else if (hit_b) begin
                  score_b_d = inc_b;
                  point_b_d = 1'b1;
                  if (inc_b == WIN_VAL) begin
                     state_d     = OVER;
                     game_over_d = 1'b1;
                     winner_d    = 1'b1;
                  end else begin
                     state_d     = SERVE;
                     serve_req_d = 1'b1;
                  end
               end
            end
            // Ball position is ignored here so a lingering ball scores once.
            SERVE: begin
               if (serve_ack) begin
                  state_d     = PLAY;
                  serve_req_d = 1'b0;
               end
            end
            OVER: begin
               state_d = OVER;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         score_a_q   <= '0;
         score_b_q   <= '0;
         point_a_q   <= 1'b0;
         point_b_q   <= 1'b0;
         serve_req_q <= 1'b0;
         game_over_q <= 1'b0;
         winner_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         score_a_q   <= score_a_d;
         score_b_q   <= score_b_d;
         point_a_q   <= point_a_d;
         point_b_q   <= point_b_d;
         serve_req_q <= serve_req_d;
         game_over_q <= game_over_d;
         winner_q    <= winner_d;
      end
   end

   assign score_a   = score_a_q;
   assign score_b   = score_b_q;
   assign point_a   = point_a_q;
   assign point_b   = point_b_q;
   assign serve_req = serve_req_q;
   assign game_over = game_over_q;
   assign winner    = winner_q;

endmodule

// File: tb/tb_pong_score_keeper.sv
// Directed bench for pong_score_keeper: default instance plus a small
// instance (SCORE_W=2, WIN_SCORE=3, COORD_W=4, BOTTOM_ROW=15).
module tb_pong_score_keeper;

   logic       clk;
   logic       rst_n;
   logic       playing, ball_valid, serve_ack;
   logic [2:0] ball_y;
   logic [3:0] score_a, score_b;
   logic       point_a, point_b, serve_req, game_over, winner;

   logic       playing2, ball_valid2, serve_ack2;
   logic [3:0] ball_y2;
   logic [1:0] score_a2, score_b2;
   logic       point_a2, point_b2, serve_req2, game_over2, winner2;

   int tests_run = 0;
   int fails     = 0;

   pong_score_keeper u_dut (
      .clk(clk), .rst_n(rst_n), .playing(playing), .ball_valid(ball_valid),
      .ball_y(ball_y), .serve_ack(serve_ack), .score_a(score_a), .score_b(score_b),
      .point_a(point_a), .point_b(point_b), .serve_req(serve_req),
      .game_over(game_over), .winner(winner)
   );

   pong_score_keeper #(
      .COORD_W(4), .TOP_ROW(0), .BOTTOM_ROW(15), .SCORE_W(2), .WIN_SCORE(3)
   ) u_small (
      .clk(clk), .rst_n(rst_n), .playing(playing2), .ball_valid(ball_valid2),
      .ball_y(ball_y2), .serve_ack(serve_ack2), .score_a(score_a2), .score_b(score_b2),
      .point_a(point_a2), .point_b(point_b2), .serve_req(serve_req2),
      .game_over(game_over2), .winner(winner2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One-cycle exit on the default instance (to_b: top row, else bottom row).
   task automatic exit_main(input bit to_b);
      ball_valid = 1'b1;
      ball_y     = to_b ? 3'd0 : 3'd7;
      step();
      ball_valid = 1'b0;
      ball_y     = 3'd3;
   endtask

   task automatic ack_main();
      serve_ack = 1'b1;
      step();
      serve_ack = 1'b0;
   endtask

   task automatic exit_small(input bit to_b);
      ball_valid2 = 1'b1;
      ball_y2     = to_b ? 4'd0 : 4'd15;
      step();
      ball_valid2 = 1'b0;
      ball_y2     = 4'd5;
   endtask

   task automatic ack_small();
      serve_ack2 = 1'b1;
      step();
      serve_ack2 = 1'b0;
   endtask

   task automatic test_reset();
      logic [7:0] outs;
      playing = 1'b1;
      step();                                    // IDLE -> PLAY
      exit_main(1'b0); ack_main();
      exit_main(1'b0); ack_main();
      exit_main(1'b0);                           // score_a = 3, SERVE
      tests_run++;
      if (score_a !== 4'd3 || serve_req !== 1'b1) begin
         fails++;
         $display("FAIL reset_pre: score_a=%0d serve_req=%b, required 3/1", score_a, serve_req);
      end
      rst_n = 1'b0;
      #1;
      outs = {score_a[0] | score_a[1] | score_a[2] | score_a[3] | (|score_b),
              point_a, point_b, serve_req, game_over, winner, 2'b00};
      tests_run++;
      if (score_a !== 4'd0 || score_b !== 4'd0 || outs !== 8'd0) begin
         fails++;
         $display("FAIL reset_async: a=%0d b=%0d pa=%b pb=%b sr=%b go=%b w=%b, required all 0",
                  score_a, score_b, point_a, point_b, serve_req, game_over, winner);
      end
      #2 rst_n = 1'b1;
      step();                                    // IDLE -> PLAY
      tests_run++;
      if (score_a !== 4'd0 || score_b !== 4'd0 || serve_req !== 1'b0) begin
         fails++;
         $display("FAIL reset_release: a=%0d b=%0d sr=%b, required 0/0/0", score_a, score_b, serve_req);
      end
   endtask

   task automatic test_single_point();
      int pulses = 0;
      ball_valid = 1'b1;
      ball_y     = 3'd7;
      for (int i = 0; i < 5; i++) begin
         step();
         if (point_a === 1'b1) pulses++;
         if (i == 0) begin
            tests_run++;
            if (point_a !== 1'b1 || score_a !== 4'd1 || serve_req !== 1'b1) begin
               fails++;
               $display("FAIL hold_first: pa=%b a=%0d sr=%b, required 1/1/1", point_a, score_a, serve_req);
            end
         end
      end
      ball_valid = 1'b0;
      tests_run++;
      if (score_a !== 4'd1 || pulses != 1 || serve_req !== 1'b1) begin
         fails++;
         $display("FAIL hold_once: a=%0d pulses=%0d sr=%b, required 1/1/1", score_a, pulses, serve_req);
      end
      ack_main();
      tests_run++;
      if (serve_req !== 1'b0) begin
         fails++;
         $display("FAIL serve_ack: serve_req=%b, required 0", serve_req);
      end
      // serve_ack while in PLAY has no effect
      ack_main();
      tests_run++;
      if (serve_req !== 1'b0 || score_a !== 4'd1 || score_b !== 4'd0) begin
         fails++;
         $display("FAIL ack_in_play: sr=%b a=%0d b=%0d, required 0/1/0", serve_req, score_a, score_b);
      end
   endtask

   task automatic test_valid_gate();
      ball_valid = 1'b0;
      ball_y     = 3'd0;
      step(); step();
      tests_run++;
      if (score_b !== 4'd0 || point_b !== 1'b0 || serve_req !== 1'b0) begin
         fails++;
         $display("FAIL invalid_ignored: b=%0d pb=%b sr=%b, required 0/0/0", score_b, point_b, serve_req);
      end
      ball_valid = 1'b1;
      step();
      ball_valid = 1'b0;
      ball_y     = 3'd3;
      tests_run++;
      if (score_b !== 4'd1 || point_b !== 1'b1 || point_a !== 1'b0) begin
         fails++;
         $display("FAIL point_b: b=%0d pb=%b pa=%b, required 1/1/0", score_b, point_b, point_a);
      end
      step();
      tests_run++;
      if (point_b !== 1'b0 || serve_req !== 1'b1) begin
         fails++;
         $display("FAIL point_b_pulse: pb=%b sr=%b, required 0/1", point_b, serve_req);
      end
      ack_main();
   endtask

   task automatic test_win_b();
      for (int i = 0; i < 7; i++) begin
         exit_main(1'b1);
         ack_main();
      end
      tests_run++;
      if (score_b !== 4'd8 || game_over !== 1'b0) begin
         fails++;
         $display("FAIL b_at_8: b=%0d go=%b, required 8/0", score_b, game_over);
      end
      exit_main(1'b1);
      tests_run++;
      if (score_b !== 4'd9 || game_over !== 1'b1 || winner !== 1'b1 || serve_req !== 1'b0 || point_b !== 1'b1) begin
         fails++;
         $display("FAIL win_b: b=%0d go=%b w=%b sr=%b pb=%b, required 9/1/1/0/1",
                  score_b, game_over, winner, serve_req, point_b);
      end
      exit_main(1'b1);
      exit_main(1'b0);
      ack_main();
      tests_run++;
      if (score_b !== 4'd9 || score_a !== 4'd1 || game_over !== 1'b1 || winner !== 1'b1 ||
          point_a !== 1'b0 || point_b !== 1'b0 || serve_req !== 1'b0) begin
         fails++;
         $display("FAIL over_frozen: a=%0d b=%0d go=%b w=%b pa=%b pb=%b sr=%b, required 1/9/1/1/0/0/0",
                  score_a, score_b, game_over, winner, point_a, point_b, serve_req);
      end
   endtask

   task automatic test_restart();
      playing = 1'b0;
      step();
      tests_run++;
      if (score_a !== 4'd0 || score_b !== 4'd0 || game_over !== 1'b0 || winner !== 1'b0) begin
         fails++;
         $display("FAIL clear: a=%0d b=%0d go=%b w=%b, required 0/0/0/0", score_a, score_b, game_over, winner);
      end
      playing = 1'b1;
      step();                                    // IDLE -> PLAY
      exit_main(1'b0);
      tests_run++;
      if (score_a !== 4'd1 || score_b !== 4'd0 || point_a !== 1'b1 || serve_req !== 1'b1) begin
         fails++;
         $display("FAIL new_game: a=%0d b=%0d pa=%b sr=%b, required 1/0/1/1", score_a, score_b, point_a, serve_req);
      end
      // playing dropped mid-serve: request falls, no pulse
      playing = 1'b0;
      step();
      tests_run++;
      if (serve_req !== 1'b0 || point_a !== 1'b0 || point_b !== 1'b0 || score_a !== 4'd0) begin
         fails++;
         $display("FAIL drop_in_serve: sr=%b pa=%b pb=%b a=%0d, required 0/0/0/0", serve_req, point_a, point_b, score_a);
      end
   endtask

   task automatic test_small_params();
      playing2 = 1'b1;
      step();
      exit_small(1'b0); ack_small();
      exit_small(1'b1); ack_small();
      exit_small(1'b0); ack_small();
      exit_small(1'b1); ack_small();
      tests_run++;
      if (score_a2 !== 2'd2 || score_b2 !== 2'd2 || game_over2 !== 1'b0) begin
         fails++;
         $display("FAIL small_2_2: a=%0d b=%0d go=%b, required 2/2/0", score_a2, score_b2, game_over2);
      end
      exit_small(1'b0);
      tests_run++;
      if (score_a2 !== 2'd3 || game_over2 !== 1'b1 || winner2 !== 1'b0 || serve_req2 !== 1'b0) begin
         fails++;
         $display("FAIL small_win_a: a=%0d go=%b w=%b sr=%b, required 3/1/0/0", score_a2, game_over2, winner2, serve_req2);
      end
      exit_small(1'b0);
      exit_small(1'b1);
      ack_small();
      tests_run++;
      if (score_a2 !== 2'd3 || score_b2 !== 2'd2 || winner2 !== 1'b0 || game_over2 !== 1'b1) begin
         fails++;
         $display("FAIL small_nowrap: a=%0d b=%0d w=%b go=%b, required 3/2/0/1", score_a2, score_b2, winner2, game_over2);
      end
   endtask

   initial begin
      rst_n       = 1'b0;
      playing     = 1'b0; ball_valid  = 1'b0; ball_y  = 3'd3; serve_ack  = 1'b0;
      playing2    = 1'b0; ball_valid2 = 1'b0; ball_y2 = 4'd5; serve_ack2 = 1'b0;
      #12;
      tests_run++;
      if (score_a !== 4'd0 || score_b !== 4'd0 || serve_req !== 1'b0 || game_over !== 1'b0 ||
          score_a2 !== 2'd0 || game_over2 !== 1'b0) begin
         fails++;
         $display("FAIL power_on_reset: a=%0d b=%0d sr=%b go=%b a2=%0d go2=%b, required all 0",
                  score_a, score_b, serve_req, game_over, score_a2, game_over2);
      end
      rst_n = 1'b1;
      step();
      test_reset();
      test_single_point();
      test_valid_gate();
      test_win_b();
      test_restart();
      test_small_params();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
